rv_int_ctrl: RTL
================

RV_INT_CTRL -- requirements
Module: rv_int_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port irq, input, 4 bits: level interrupt sources; index 0 has highest priority.
REQ-004 SHALL have port ecall, input, 1 bit: environment-call pulse from decode.
REQ-005 SHALL have port ill_instr, input, 1 bit: illegal-instruction pulse from decode.
REQ-006 SHALL have port mret, input, 1 bit: trap-return pulse.
REQ-007 SHALL have port pc_next, input, 32 bits: return address captured at trap acceptance.
REQ-008 SHALL have ports cfg_we (input, 1 bit) and cfg_wdata (input, 5 bits): configuration write; bit4 = global MIE, bits3:0 = per-source enables.
REQ-009 SHALL have ports trap_valid (output, 1 bit) and trap_ready (input, 1 bit): trap request handshake to the PC unit.
REQ-010 SHALL have outputs trap_vector (32 bits), trap_cause (32 bits) and epc (32 bits).
REQ-011 SHALL have outputs in_service (1 bit), pending (4 bits) and drop_err (1 bit, sticky).

Function
REQ-012 SHALL set pending[i] on a 0->1 edge of irq[i], detected against a registered copy; pending[i] SHALL clear in the cycle source i is granted; a set and a clear in the same cycle SHALL leave pending[i] set.
REQ-013 SHALL implement states IDLE, REQ, SERVICE; trap_valid SHALL be 1 only in REQ.
REQ-014 In IDLE, SHALL choose the event by priority ill_instr > ecall > interrupt; an interrupt SHALL be eligible only when MIE=1 and (pending & enables) != 0, and the lowest eligible index SHALL win.
REQ-015 On selection in IDLE, SHALL register epc=pc_next, trap_cause and trap_vector, and enter REQ on the next cycle, giving 1-cycle latency from event to trap_valid.
REQ-016 Cause/vector encoding: ill_instr -> cause 0x0000_0002, vector 0x0000_0004; ecall -> cause 0x0000_000B, vector 0x0000_0008; irq i -> cause 0x8000_0010+i, vector per REQ-026.
REQ-017 In REQ, trap_vector, trap_cause and epc SHALL stay stable until trap_valid && trap_ready; on the handshake cycle, SHALL go to SERVICE, copy MIE to MPIE and clear MIE.
REQ-018 in_service SHALL be 1 in SERVICE.
REQ-019 mret in SERVICE SHALL return the block to IDLE and restore MIE from MPIE.
REQ-020 mret in IDLE or REQ SHALL be ignored.
REQ-021 ecall or ill_instr arriving in REQ or SERVICE SHALL be dropped and SHALL set drop_err; drop_err SHALL clear only on reset.
REQ-022 cfg_we SHALL update the enables in any state.
REQ-023 A cfg_we MIE write SHALL write MIE in IDLE and REQ, and SHALL write MPIE in SERVICE.
REQ-024 Interrupt edges SHALL keep accumulating in pending in every state.

Reset
REQ-025 On rstn=0 at a clock edge, SHALL take this state regardless of the current state (including mid-handshake):
- state IDLE;
- trap_valid=0, in_service=0, pending=0, drop_err=0;
- MIE=0, MPIE=0, enables=0;
- trap_vector, trap_cause and epc = 0;
- irq edge registers = 0.

Configuration
REQ-026 Macro RV_INT_VECTORED_EN:
- defined: irq i vector = 0x0000_0010 + 4*i;
- undefined: every interrupt vector = 0x0000_000C;
- exception vectors SHALL be identical in both builds.

Structure
REQ-027 Shared package SHALL hold:
- the state enum (IDLE/REQ/SERVICE);
- the cause constants (2, 11, 0x8000_0010 base);
- the vector constants (0x04, 0x08, 0x0C, 0x10);
- the source count (4).
REQ-028 SHALL instantiate one sub-module, rv_int_prio: a combinational fixed-priority encoder with 4-bit request input and outputs grant-valid plus a 2-bit index.

Verification
REQ-029 MIE=1, enables=0xF; irq=0b0110 rising together -> trap_valid next cycle with cause 0x8000_0011; after handshake, pending=0b0100.
REQ-030 IDLE; ecall and ill_instr pulsed together with pc_next=0x40 -> cause 0x2, vector 0x4, epc 0x40; ecall dropped with no drop_err, because it lost in the same cycle rather than arriving in REQ/SERVICE.
REQ-031 trap_ready held 0 for 5 cycles -> trap_valid and outputs stable throughout; handshake -> in_service=1 and MIE=0; a further irq edge only sets pending.
REQ-032 In SERVICE, ecall pulse -> drop_err=1; then mret -> IDLE with MIE restored to 1; pending irq2 -> new trap next cycles with cause 0x8000_0012.
REQ-033 rstn=0 asserted while in REQ -> next cycle trap_valid=0, pending=0, MIE=0, state IDLE; with RV_INT_VECTORED_EN defined, irq3 -> vector 0x1C, and undefined -> vector 0x0C.

Source files
------------

// File: rtl/rv_int_ctrl_pkg.sv
// Shared types and constants for the rv_int_ctrl trap/interrupt controller.
package rv_int_ctrl_pkg;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned XLEN    = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] CAUSE_ILL      = 32'h0000_0002;
  localparam logic [XLEN-1:0] CAUSE_ECALL    = 32'h0000_000B;
  localparam logic [XLEN-1:0] CAUSE_IRQ_BASE = 32'h8000_0010;

  localparam logic [XLEN-1:0] VEC_ILL        = 32'h0000_0004;
  localparam logic [XLEN-1:0] VEC_ECALL      = 32'h0000_0008;
  localparam logic [XLEN-1:0] VEC_IRQ_COMMON = 32'h0000_000C;
  localparam logic [XLEN-1:0] VEC_IRQ_BASE   = 32'h0000_0010;

endpackage

// File: rtl/rv_int_ctrl_if.sv
// Trap request bus between the interrupt controller and the PC unit.
interface rv_int_ctrl_if;

  logic        trap_valid;
  logic        trap_ready;
  logic [31:0] trap_vector;
  logic [31:0] trap_cause;
  logic [31:0] epc;

  modport master (
    output trap_valid,
    output trap_vector,
    output trap_cause,
    output epc,
    input  trap_ready
  );

  modport slave (
    input  trap_valid,
    input  trap_vector,
    input  trap_cause,
    input  epc,
    output trap_ready
  );

endinterface

// File: rtl/rv_int_ctrl_prio.sv
// rv_int_prio: combinational fixed-priority encoder, lowest index wins.
module rv_int_prio
  import rv_int_ctrl_pkg::*;
(
  input  logic [NUM_SRC-1:0] req_i,
  output logic               gnt_valid_c_o,
  output logic [IDX_W-1:0]   gnt_idx_c_o
);

  // Scan from the top down so the lowest requesting index is the last writer.
  always_comb begin
    gnt_valid_c_o = 1'b0;
    gnt_idx_c_o   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_valid_c_o = 1'b1;
        gnt_idx_c_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rv_int_ctrl.sv
// rv_int_ctrl: trap/interrupt controller (IDLE -> REQ -> SERVICE).
// Build option: define RV_INT_VECTORED_EN for per-source interrupt vectors.
module rv_int_ctrl
  import rv_int_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic [NUM_SRC-1:0]  irq,
  input  logic                ecall,
  input  logic                ill_instr,
  input  logic                mret,
  input  logic [XLEN-1:0]     pc_next,
  input  logic                cfg_we,
  input  logic [4:0]          cfg_wdata,
  rv_int_ctrl_if.master       trap_if,
  output logic                in_service,
  output logic [NUM_SRC-1:0]  pending,
  output logic                drop_err
);

  state_e               state_q, state_d;
  logic [NUM_SRC-1:0]   irq_q, pending_q, pending_d, en_q, en_d, clr_mask;
  logic                 mie_q, mie_d, mpie_q, mpie_d, drop_q, drop_d;
  logic [XLEN-1:0]      epc_q, epc_d, cause_q, cause_d, vector_q, vector_d;
  logic [XLEN-1:0]      irq_vec;
  logic                 trap_valid_q, in_service_q;
  logic [NUM_SRC-1:0]   eligible;
  logic                 gnt_valid;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 take;

  assign eligible = mie_q ? (pending_q & en_q) : '0;

  rv_int_prio u_prio (
    .req_i         (eligible),
    .gnt_valid_c_o (gnt_valid),
    .gnt_idx_c_o   (gnt_idx)
  );

  assign take = ill_instr | ecall | gnt_valid;

`ifdef RV_INT_VECTORED_EN
  assign irq_vec = VEC_IRQ_BASE + (XLEN'(gnt_idx) << 2);
`else
  assign irq_vec = VEC_IRQ_COMMON;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (take)               state_d = ST_REQ;
      ST_REQ:     if (trap_if.trap_ready) state_d = ST_SERVICE;
      ST_SERVICE: if (mret)               state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: trap capture, MIE/MPIE stack, pending, drop flag.
  always_comb begin
    epc_d    = epc_q;
    cause_d  = cause_q;
    vector_d = vector_q;
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    drop_d   = drop_q;
    clr_mask = '0;
    en_d     = cfg_we ? cfg_wdata[NUM_SRC-1:0] : en_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_we) mie_d = cfg_wdata[4];
        if (ill_instr) begin
          epc_d    = pc_next;
          cause_d  = CAUSE_ILL;
          vector_d = VEC_ILL;
        end else if (ecall) begin
          epc_d    = pc_next;
          cause_d  = CAUSE_ECALL;
          vector_d = VEC_ECALL;
        end else if (gnt_valid) begin
          epc_d    = pc_next;
          cause_d  = CAUSE_IRQ_BASE + XLEN'(gnt_idx);
          vector_d = irq_vec;
          clr_mask = NUM_SRC'(1) << gnt_idx;
        end
      end
      ST_REQ: begin
        if (ecall || ill_instr) drop_d = 1'b1;
        if (cfg_we) mie_d = cfg_wdata[4];
        if (trap_if.trap_ready) begin
          mpie_d = mie_d;
          mie_d  = 1'b0;
        end
      end
      ST_SERVICE: begin
        if (ecall || ill_instr) drop_d = 1'b1;
        if (cfg_we) mpie_d = cfg_wdata[4];
        if (mret) mie_d = mpie_d;
      end
      default: ;
    endcase
    // A new edge wins over a same-cycle grant clear.
    pending_d = (pending_q & ~clr_mask) | (irq & ~irq_q);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      irq_q        <= '0;
      pending_q    <= '0;
      en_q         <= '0;
      mie_q        <= 1'b0;
      mpie_q       <= 1'b0;
      drop_q       <= 1'b0;
      epc_q        <= '0;
      cause_q      <= '0;
      vector_q     <= '0;
      trap_valid_q <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      irq_q        <= irq;
      pending_q    <= pending_d;
      en_q         <= en_d;
      mie_q        <= mie_d;
      mpie_q       <= mpie_d;
      drop_q       <= drop_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
      vector_q     <= vector_d;
      trap_valid_q <= (state_d == ST_REQ);
      in_service_q <= (state_d == ST_SERVICE);
    end
  end

  assign trap_if.trap_valid  = trap_valid_q;
  assign trap_if.trap_vector = vector_q;
  assign trap_if.trap_cause  = cause_q;
  assign trap_if.epc         = epc_q;
  assign in_service          = in_service_q;
  assign pending             = pending_q;
  assign drop_err            = drop_q;

endmodule
